// File: rtl/tick_gen_bank.sv
// tick_gen_bank
//   Bank of NUM_CH programmable clock-enable generators plus a power-on
//   hold-off timer. Everything runs in the clk domain.
//
//   Ports
//     clk           system clock
//     clk_rst       asynchronous reset, active-low
//     div_count     packed divide values, channel i = [i*CNT_W +: CNT_W]
//                   (0 is treated as 1)
//     ch_en         per-channel run enable (0 = pause, count is held)
//     sync_restart  phase-align all channels (only with TICK_GEN_SYNC_RESTART_EN)
//     tick          one-cycle pulse per channel period
//     clk_div       level toggling on every tick (period 2*D)
//     on_sw         power-on hold-off elapsed, sticky until reset
//
//   Optional feature macro: TICK_GEN_SYNC_RESTART_EN
//     defined   -> sync_restart port present; when high on an edge every
//                  channel reloads cnt=0, tick=0, clk_div=0 (POR unaffected)
//     undefined -> port and logic absent; channels align only via reset
module tick_gen_bank #(
   parameter int NUM_CH     = 4,
   parameter int CNT_W      = 32,
   parameter int POR_CYCLES = 94500000,
   parameter int POR_W      = 27
) (
   input  logic                    clk,
   input  logic                    clk_rst,
   input  logic [NUM_CH*CNT_W-1:0] div_count,
   input  logic [NUM_CH-1:0]       ch_en,
`ifdef TICK_GEN_SYNC_RESTART_EN
   input  logic                    sync_restart,
`endif
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       clk_div,
   output logic                    on_sw
);

   localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [CNT_W-1:0] div_val;
      logic [CNT_W-1:0] term_val;
      logic [CNT_W-1:0] cnt;
      logic             tick_q;
      logic             div_q;

      // D==0 behaves as D==1, so the terminal count is 0 in both cases.
      assign div_val  = div_count[g*CNT_W +: CNT_W];
      assign term_val = (div_val == '0) ? '0 : div_val - CNT_W'(1);

      // The >= compare lets a lowered divide value wrap on the next enabled
      // edge instead of running the counter all the way around.
      always_ff @(posedge clk or negedge clk_rst) begin
         if (!clk_rst) begin
            cnt    <= '0;
            tick_q <= 1'b0;
            div_q  <= 1'b0;
         end
`ifdef TICK_GEN_SYNC_RESTART_EN
         else if (sync_restart) begin
            cnt    <= '0;
            tick_q <= 1'b0;
            div_q  <= 1'b0;
         end
`endif
         else if (ch_en[g]) begin
            if (cnt >= term_val) begin
               cnt    <= '0;
               tick_q <= 1'b1;
               div_q  <= ~div_q;
            end else begin
               cnt    <= cnt + CNT_W'(1);
               tick_q <= 1'b0;
            end
         end else begin
            tick_q <= 1'b0;
         end
      end

      assign tick[g]    = tick_q;
      assign clk_div[g] = div_q;
   end

   logic [POR_W-1:0] por_cnt;

   // por_cnt stops at POR_LAST once on_sw is set.
   always_ff @(posedge clk or negedge clk_rst) begin
      if (!clk_rst) begin
         por_cnt <= '0;
         on_sw   <= 1'b0;
      end else if (!on_sw) begin
         if (por_cnt == POR_LAST) begin
            on_sw <= 1'b1;
         end else begin
            por_cnt <= por_cnt + POR_W'(1);
         end
      end
   end

endmodule
